// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO accumulator registers.
// Define MULDIV_DIV_EN to compile in the restoring divider; otherwise DIV/DIVU decode as illegal.
//   state  | meaning
//   IDLE   | waiting for Start; single-cycle ops complete here
//   ITER   | one multiply/divide bit per cycle
//   FINISH | sign fix-up and HI/LO write-back
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ITER   = 2'b01;
    localparam logic [1:0] S_FINISH = 2'b10;
    localparam logic [1:0] K_MULT = 2'b00;
    localparam logic [1:0] K_MADD = 2'b01;
    localparam logic [1:0] K_MSUB = 2'b10;
    localparam logic [1:0] K_DIV  = 2'b11;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         kind_q, kind_d;
    logic               sign_q, sign_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    logic               op_signed, op_mul, div_go, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fin;

    assign op_signed = ~Op[0];
    assign op_mul    = (Op <= 4'd5);
    assign mag_a     = (op_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b     = (op_signed && B[WIDTH-1]) ? -B : B;
    assign prod_fin  = sign_q ? -prod_q : prod_q;

`ifdef MULDIV_DIV_EN
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   shifted, diff;
    logic             op_div;

    assign op_div   = (Op[3:1] == 3'b011);
    assign div_go   = op_div && (B != '0);
    assign div_zero = op_div && (B == '0);
    assign shifted  = {rem_q, a_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, b_q};
`else
    assign div_go   = 1'b0;
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        sign_d  = sign_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
`ifdef MULDIV_DIV_EN
        rsign_d = rsign_q;
        rem_d   = rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (op_mul || div_go) begin
                        state_d = S_ITER;
                        cnt_d   = '0;
                        prod_d  = '0;
                        kind_d  = Op[2:1];
                        a_d     = {{WIDTH{1'b0}}, mag_a};
                        b_d     = mag_b;
                        sign_d  = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                        rsign_d = op_signed & A[WIDTH-1];
                        rem_d   = '0;
`endif
                    end else begin
                        done_d = 1'b1;
                        dbz_d  = div_zero;
                        if (Op == 4'b1000) hi_d = A;
                        if (Op == 4'b1001) lo_d = A;
                    end
                end
            end
            S_ITER: begin
                cnt_d  = cnt_q + CW'(1);
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
                prod_d = b_q[0] ? prod_q + a_q : prod_q;
`ifdef MULDIV_DIV_EN
                // Restoring step: the quotient bit shifts into the vacated dividend LSB.
                if (kind_q == K_DIV) begin
                    a_d    = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], ~diff[WIDTH]};
                    b_d    = b_q;
                    prod_d = prod_q;
                    rem_d  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                end
`endif
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (kind_q)
                    K_MULT:  {hi_d, lo_d} = prod_fin;
                    K_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_fin;
                    K_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_fin;
`ifdef MULDIV_DIV_EN
                    K_DIV: begin
                        lo_d = sign_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
                        hi_d = rsign_q ? -rem_q : rem_q;
                    end
`endif
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kind_q  <= K_MULT;
            sign_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            rsign_q <= 1'b0;
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            sign_q  <= sign_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef MULDIV_DIV_EN
            rsign_q <= rsign_d;
            rem_q   <= rem_d;
`endif
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
// Divide expectations follow whether MULDIV_DIV_EN is defined for the build.
module tb_muldiv_unit;
`ifdef MULDIV_DIV_EN
    localparam bit DIVEN = 1'b1;
`else
    localparam bit DIVEN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  Op = 4'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    int checks = 0;
    int failures = 0;
    int lat, bc;
    logic dbz, saw_done;
    logic [31:0] eh, el;

    muldiv_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // lat counts edges after the accept edge until Done is seen; bc counts Busy samples.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int l, output int busy_cyc, output logic dz);
        @(negedge Clk);
        Op = op; A = a; B = b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        l = 0;
        busy_cyc = 0;
        while (Done !== 1'b1 && l < 100) begin
            if (Busy) busy_cyc++;
            @(posedge Clk); #1;
            l++;
        end
        dz = DivByZero;
        @(posedge Clk); #1;
        chk("done_pulse", {63'd0, Done}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        chk("rst_dbz", {63'd0, DivByZero}, 64'd0);
        chk("rst_hi", {32'd0, Hi}, 64'd0);
        chk("rst_lo", {32'd0, Lo}, 64'd0);
        @(negedge Clk);
        Rst = 1'b0;

        run_op(4'b0000, 32'hFFFF_FFFE, 32'd3, lat, bc, dbz);
        chk("mult_lat", lat, 33);
        chk("mult_busy", bc, 33);
        chk("mult_hi", {32'd0, Hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, Lo}, 64'hFFFF_FFFA);
        chk("mult_dbz", {63'd0, dbz}, 64'd0);

        run_op(4'b1000, 32'd0, 32'd0, lat, bc, dbz);
        chk("mthi_lat", lat, 0);
        chk("mthi_busy", bc, 0);
        chk("mthi_hi", {32'd0, Hi}, 64'd0);
        chk("mthi_lo_kept", {32'd0, Lo}, 64'hFFFF_FFFA);
        run_op(4'b1001, 32'd10, 32'd0, lat, bc, dbz);
        chk("mtlo_lo", {32'd0, Lo}, 64'd10);
        chk("mtlo_hi_kept", {32'd0, Hi}, 64'd0);

        // 0xFFFFFFFF*2 = 0x1_FFFFFFFE; plus 0x0_0000000A = 0x2_00000008
        run_op(4'b0011, 32'hFFFF_FFFF, 32'd2, lat, bc, dbz);
        chk("maddu_lat", lat, 33);
        chk("maddu_hilo", {Hi, Lo}, 64'h0000_0002_0000_0008);

        run_op(4'b1000, 32'd0, 32'd0, lat, bc, dbz);
        run_op(4'b1001, 32'd0, 32'd0, lat, bc, dbz);
        run_op(4'b0100, 32'd1, 32'd1, lat, bc, dbz);
        chk("msub_hilo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(4'b0000, 32'd5, 32'hFFFF_FFFC, lat, bc, dbz);
        chk("mult_neg_hilo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEC);

        run_op(4'b1000, 32'h1234, 32'd0, lat, bc, dbz);
        run_op(4'b1001, 32'h5678, 32'd0, lat, bc, dbz);

        run_op(4'b0110, 32'hFFFF_FFF9, 32'd2, lat, bc, dbz);
        chk("div_lat", lat, DIVEN ? 33 : 0);
        chk("div_lo", {32'd0, Lo}, DIVEN ? 64'hFFFF_FFFD : 64'h5678);
        chk("div_hi", {32'd0, Hi}, DIVEN ? 64'hFFFF_FFFF : 64'h1234);
        chk("div_dbz", {63'd0, dbz}, 64'd0);

        run_op(4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dbz);
        chk("div_min_lo", {32'd0, Lo}, DIVEN ? 64'h8000_0000 : 64'h5678);
        chk("div_min_hi", {32'd0, Hi}, DIVEN ? 64'h0 : 64'h1234);

        run_op(4'b0111, 32'd100, 32'd7, lat, bc, dbz);
        chk("divu_lo", {32'd0, Lo}, DIVEN ? 64'd14 : 64'h5678);
        chk("divu_hi", {32'd0, Hi}, DIVEN ? 64'd2 : 64'h1234);

        eh = DIVEN ? 32'd2 : 32'h1234;
        el = DIVEN ? 32'd14 : 32'h5678;
        run_op(4'b0111, 32'd5, 32'd0, lat, bc, dbz);
        chk("dbz_lat", lat, 0);
        chk("dbz_busy", bc, 0);
        chk("dbz_flag", {63'd0, dbz}, {63'd0, DIVEN});
        chk("dbz_hilo", {Hi, Lo}, {eh, el});

        run_op(4'b1111, 32'd9, 32'd9, lat, bc, dbz);
        chk("illegal_lat", lat, 0);
        chk("illegal_dbz", {63'd0, dbz}, 64'd0);
        chk("illegal_hilo", {Hi, Lo}, {eh, el});

        run_op(4'b1000, 32'hAAAA, 32'd0, lat, bc, dbz);
        run_op(4'b1001, 32'hBBBB, 32'd0, lat, bc, dbz);
        @(negedge Clk);
        Op = 4'b0001; A = 32'h0001_0000; B = 32'h0001_0000; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("abort_busy", {63'd0, Busy}, 64'd1);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Op = 4'b1001; A = 32'hDEAD; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("ignored_lo", {32'd0, Lo}, 64'hBBBB);
        chk("ignored_busy", {63'd0, Busy}, 64'd1);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("abort_busy0", {63'd0, Busy}, 64'd0);
        chk("abort_hilo", {Hi, Lo}, 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Done) saw_done = 1'b1;
        end
        chk("abort_no_done", {63'd0, saw_done}, 64'd0);
        chk("abort_hilo_after", {Hi, Lo}, 64'd0);

        run_op(4'b0001, 32'd5, 32'd7, lat, bc, dbz);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_hilo", {Hi, Lo}, 64'd35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
